// File: rtl/aes_package.sv
// Shared types and constants for the AES job sequencer and the control block.
package aes_package;

  localparam int AES_BLOCK_WORDS = 4;
  localparam int AES_CNT_WIDTH   = 16;

  typedef enum logic [2:0] {
    IDLE,
    KEY_REQ,
    KEY_LOAD,
    EXPAND,
    DATA_REQ,
    RUN,
    DRAIN,
    DONE
  } aes_fsm_state_t;

  typedef struct packed {
    logic                     start;
    logic [AES_CNT_WIDTH-1:0] n_blocks;
    logic [31:0]              key_addr;
    logic [31:0]              src_addr;
    logic [31:0]              dst_addr;
  } ctrl_fsm_t;

  typedef struct packed {
    logic                     busy;
    logic                     done;
    logic [AES_CNT_WIDTH-1:0] blocks_done;
  } flags_fsm_t;

endpackage

// File: rtl/aes_block_counter.sv
// Saturating block counter: zeroed by clear or load, counts up to limit_i and
// flags the increment that lands exactly on the limit.
module aes_block_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             hit_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   countInc;
  logic             atLimit;

  assign countInc = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
  assign atLimit  = (count_q == limit_i);
  assign hit_o    = inc_i && !atLimit && (countInc == {1'b0, limit_i});
  assign count_o  = count_q;

  // Next count: clear/load win, otherwise step up but never past the limit.
  always_comb begin
    count_d = count_q;
    if (clear_i || load_i) begin
      count_d = '0;
    end else if (inc_i && !atLimit) begin
      count_d = countInc[WIDTH-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/aes_fsm.sv
// AES HWPE job sequencer: key load, key expansion, data streaming and
// block counting, finishing with a one-cycle done pulse.
module aes_fsm
  import aes_package::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int KEY_WORDS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] n_blocks_i,
  input  logic [31:0]          key_addr_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  output logic                 src_req_o,
  output logic [31:0]          src_addr_o,
  output logic [CNT_WIDTH+1:0] src_len_o,
  input  logic                 src_ack_i,
  input  logic                 src_done_i,
  output logic                 sink_req_o,
  output logic [31:0]          sink_addr_o,
  output logic [CNT_WIDTH+1:0] sink_len_o,
  input  logic                 sink_ack_i,
  input  logic                 sink_done_i,
  output logic                 eng_key_mode_o,
  output logic                 eng_expand_o,
  input  logic                 eng_expand_done_i,
  output logic                 eng_run_o,
  input  logic                 eng_block_done_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] blocks_done_o
);

  localparam int LEN_WIDTH = CNT_WIDTH + 2;
  localparam logic [LEN_WIDTH-1:0] KEY_LEN = LEN_WIDTH'(KEY_WORDS);

  aes_fsm_state_t state_q, state_d;
  logic srcAcked_q, srcAcked_d;
  logic sinkAcked_q, sinkAcked_d;
  logic sinkSeen_q, sinkSeen_d;

  logic [CNT_WIDTH-1:0] nBlocks_q;
  logic [31:0] keyAddr_q, srcAddr_q, dstAddr_q;
  logic [31:0] keyAddrJob;
  logic [LEN_WIDTH-1:0] dataLen;

  logic srcReq_d, sinkReq_d, keyMode_d, expand_d, run_d, busy_d, done_d;
  logic [31:0] srcAddr_d, sinkAddr_d;
  logic [LEN_WIDTH-1:0] srcLen_d, sinkLen_d;

  logic accept, blockInc, blockHit;

  assign accept     = (state_q == IDLE) && start_i && !clear_i;
  assign blockInc   = (state_q == RUN) && eng_block_done_i;
  assign keyAddrJob = (state_q == IDLE) ? key_addr_i : keyAddr_q;
  assign dataLen    = LEN_WIDTH'(nBlocks_q) * LEN_WIDTH'(AES_BLOCK_WORDS);

  aes_block_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .load_i (accept),
    .inc_i  (blockInc),
    .limit_i(nBlocks_q),
    .count_o(blocks_done_o),
    .hit_o  (blockHit)
  );

  // Next state and handshake bookkeeping; clear overrides everything.
  always_comb begin
    state_d     = state_q;
    srcAcked_d  = srcAcked_q;
    sinkAcked_d = sinkAcked_q;
    sinkSeen_d  = sinkSeen_q;
    case (state_q)
      IDLE: begin
        srcAcked_d  = 1'b0;
        sinkAcked_d = 1'b0;
        sinkSeen_d  = 1'b0;
        if (start_i) state_d = (n_blocks_i == '0) ? DONE : KEY_REQ;
      end
      KEY_REQ:  if (src_ack_i) state_d = KEY_LOAD;
      KEY_LOAD: if (src_done_i) state_d = EXPAND;
      EXPAND:   if (eng_expand_done_i) state_d = DATA_REQ;
      DATA_REQ: begin
        srcAcked_d  = srcAcked_q | src_ack_i;
        sinkAcked_d = sinkAcked_q | sink_ack_i;
        sinkSeen_d  = sinkSeen_q | sink_done_i;
        if (srcAcked_d && sinkAcked_d) state_d = RUN;
      end
      RUN: begin
        sinkSeen_d = sinkSeen_q | sink_done_i;
        if (blockHit) state_d = DRAIN;
      end
      DRAIN: if (sink_done_i || sinkSeen_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d     = IDLE;
      srcAcked_d  = 1'b0;
      sinkAcked_d = 1'b0;
      sinkSeen_d  = 1'b0;
    end
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    srcReq_d   = 1'b0;
    srcAddr_d  = '0;
    srcLen_d   = '0;
    sinkReq_d  = 1'b0;
    sinkAddr_d = '0;
    sinkLen_d  = '0;
    if (state_d == KEY_REQ) begin
      srcReq_d  = 1'b1;
      srcAddr_d = keyAddrJob;
      srcLen_d  = KEY_LEN;
    end else if (state_d == DATA_REQ) begin
      srcReq_d   = !srcAcked_d;
      srcAddr_d  = srcAddr_q;
      srcLen_d   = dataLen;
      sinkReq_d  = !sinkAcked_d;
      sinkAddr_d = dstAddr_q;
      sinkLen_d  = dataLen;
    end
    keyMode_d = (state_d == KEY_REQ) || (state_d == KEY_LOAD);
    expand_d  = (state_q == KEY_LOAD) && (state_d == EXPAND);
    run_d     = (state_d == RUN);
    busy_d    = (state_d != IDLE) && (state_d != DONE);
    done_d    = (state_d == DONE);
  end

  // State and handshake flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      srcAcked_q  <= 1'b0;
      sinkAcked_q <= 1'b0;
      sinkSeen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      srcAcked_q  <= srcAcked_d;
      sinkAcked_q <= sinkAcked_d;
      sinkSeen_q  <= sinkSeen_d;
    end
  end

  // Job registers, captured once per accepted start and held for the job.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nBlocks_q <= '0;
      keyAddr_q <= '0;
      srcAddr_q <= '0;
      dstAddr_q <= '0;
    end else if (accept) begin
      nBlocks_q <= n_blocks_i;
      keyAddr_q <= key_addr_i;
      srcAddr_q <= src_addr_i;
      dstAddr_q <= dst_addr_i;
    end
  end

  // Registered outputs towards streamer, engine and control.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_req_o      <= 1'b0;
      src_addr_o     <= '0;
      src_len_o      <= '0;
      sink_req_o     <= 1'b0;
      sink_addr_o    <= '0;
      sink_len_o     <= '0;
      eng_key_mode_o <= 1'b0;
      eng_expand_o   <= 1'b0;
      eng_run_o      <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      src_req_o      <= srcReq_d;
      src_addr_o     <= srcAddr_d;
      src_len_o      <= srcLen_d;
      sink_req_o     <= sinkReq_d;
      sink_addr_o    <= sinkAddr_d;
      sink_len_o     <= sinkLen_d;
      eng_key_mode_o <= keyMode_d;
      eng_expand_o   <= expand_d;
      eng_run_o      <= run_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
    end
  end

endmodule

// File: tb/tb_aes_fsm.sv
// Self-checking bench for the AES job sequencer; the bench plays streamer and
// engine, and a scoreboard checks each completed job at its done pulse.
module tb_aes_fsm;

  localparam int CW = 16;

  typedef struct {
    int blocks;
    int expands;
  } expT;

  logic          clk_i = 1'b0;
  logic          rst_ni, clear_i, start_i;
  logic [CW-1:0] n_blocks_i;
  logic [31:0]   key_addr_i, src_addr_i, dst_addr_i;
  logic          src_req_o, src_ack_i, src_done_i;
  logic [31:0]   src_addr_o, sink_addr_o;
  logic [CW+1:0] src_len_o, sink_len_o;
  logic          sink_req_o, sink_ack_i, sink_done_i;
  logic          eng_key_mode_o, eng_expand_o, eng_expand_done_i;
  logic          eng_run_o, eng_block_done_i, busy_o, done_o;
  logic [CW-1:0] blocks_done_o;

  int assertCount = 0;
  int failCount = 0;
  int expandCnt = 0;
  int reqCnt = 0;
  expT expQ[$];

  aes_fsm #(.CNT_WIDTH(CW), .KEY_WORDS(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .n_blocks_i(n_blocks_i), .key_addr_i(key_addr_i), .src_addr_i(src_addr_i),
    .dst_addr_i(dst_addr_i), .src_req_o(src_req_o), .src_addr_o(src_addr_o),
    .src_len_o(src_len_o), .src_ack_i(src_ack_i), .src_done_i(src_done_i),
    .sink_req_o(sink_req_o), .sink_addr_o(sink_addr_o), .sink_len_o(sink_len_o),
    .sink_ack_i(sink_ack_i), .sink_done_i(sink_done_i),
    .eng_key_mode_o(eng_key_mode_o), .eng_expand_o(eng_expand_o),
    .eng_expand_done_i(eng_expand_done_i), .eng_run_o(eng_run_o),
    .eng_block_done_i(eng_block_done_i), .busy_o(busy_o), .done_o(done_o),
    .blocks_done_o(blocks_done_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] allOutputs();
    return {5'd0, src_req_o, src_addr_o, src_len_o, sink_req_o, sink_addr_o,
            sink_len_o, eng_key_mode_o, eng_expand_o, eng_run_o, busy_o,
            done_o, blocks_done_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard side: tally activity per job and check it when done pulses.
  always @(negedge clk_i) begin
    expT e;
    if (start_i && !busy_o && !done_o) begin
      expandCnt = 0;
      reqCnt = 0;
    end
    if (eng_expand_o) expandCnt++;
    if (src_req_o || sink_req_o) reqCnt++;
    if (done_o) begin
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("doneBlocks", blocks_done_o, e.blocks);
        checkOutput("expandPulses", expandCnt, e.expands);
        if (e.blocks == 0) checkOutput("zeroJobNoReq", reqCnt, 0);
      end else begin
        checkOutput("spuriousDone", done_o, 1'b0);
      end
    end
  end

  // Issue a start and record what the job should end with.
  task automatic applyStimulus(input int n, input logic [31:0] key,
                               input logic [31:0] src, input logic [31:0] dst);
    expT e;
    e.blocks = n;
    e.expands = (n == 0) ? 0 : 1;
    expQ.push_back(e);
    start_i = 1'b1;
    n_blocks_i = CW'(n);
    key_addr_i = key;
    src_addr_i = src;
    dst_addr_i = dst;
    tick();
    start_i = 1'b0;
    n_blocks_i = CW'($urandom);
    key_addr_i = $urandom;
    src_addr_i = $urandom;
    dst_addr_i = $urandom;
  endtask

  task automatic keyPhase(input logic [31:0] key);
    checkOutput("keyReq", src_req_o, 1'b1);
    checkOutput("keyAddr", src_addr_o, key);
    checkOutput("keyLen", src_len_o, 4);
    checkOutput("keyMode", eng_key_mode_o, 1'b1);
    checkOutput("busyKey", busy_o, 1'b1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checkOutput("keyReqHeld", src_req_o, 1'b1);
    src_ack_i = 1'b1;
    tick();
    src_ack_i = 1'b0;
    checkOutput("keyReqDrop", src_req_o, 1'b0);
    checkOutput("keyModeLoad", eng_key_mode_o, 1'b1);
  endtask

  task automatic expandPhase();
    tick();
    src_done_i = 1'b1;
    tick();
    src_done_i = 1'b0;
    checkOutput("expandPulse", eng_expand_o, 1'b1);
    checkOutput("keyModeOff", eng_key_mode_o, 1'b0);
    tick();
    checkOutput("expandOneCycle", eng_expand_o, 1'b0);
    eng_expand_done_i = 1'b1;
    tick();
    eng_expand_done_i = 1'b0;
  endtask

  task automatic dataPhase(input int n, input logic [31:0] src,
                           input logic [31:0] dst, input int srcDly,
                           input int sinkDly);
    int maxDly;
    maxDly = (srcDly > sinkDly) ? srcDly : sinkDly;
    checkOutput("dataSrcReq", src_req_o, 1'b1);
    checkOutput("dataSinkReq", sink_req_o, 1'b1);
    checkOutput("dataSrcAddr", src_addr_o, src);
    checkOutput("dataSinkAddr", sink_addr_o, dst);
    checkOutput("dataSrcLen", src_len_o, n * 4);
    checkOutput("dataSinkLen", sink_len_o, n * 4);
    for (int c = 0; c <= maxDly; c++) begin
      src_ack_i = (c == srcDly);
      sink_ack_i = (c == sinkDly);
      tick();
      src_ack_i = 1'b0;
      sink_ack_i = 1'b0;
      checkOutput("skewSrcReq", src_req_o, c < srcDly);
      checkOutput("skewSinkReq", sink_req_o, c < sinkDly);
      checkOutput("skewRun", eng_run_o, c >= maxDly);
    end
  endtask

  task automatic blockPhase(input int count, input int earlySinkAt);
    for (int b = 0; b < count; b++) begin
      tick();
      eng_block_done_i = 1'b1;
      sink_done_i = (b == earlySinkAt);
      tick();
      eng_block_done_i = 1'b0;
      sink_done_i = 1'b0;
      checkOutput("blocksDone", blocks_done_o, b + 1);
    end
  endtask

  task automatic finishJob(input int n, input bit early, input bit extra);
    checkOutput("drainRunOff", eng_run_o, 1'b0);
    eng_block_done_i = extra;
    tick();
    eng_block_done_i = 1'b0;
    if (!early) begin
      checkOutput("drainNoDone", done_o, 1'b0);
      checkOutput("drainBusy", busy_o, 1'b1);
      tick();
      sink_done_i = 1'b1;
      tick();
      sink_done_i = 1'b0;
    end
    checkOutput("donePulse", done_o, 1'b1);
    checkOutput("doneBusyLow", busy_o, 1'b0);
    checkOutput("doneCount", blocks_done_o, n);
    tick();
    checkOutput("doneOneCycle", done_o, 1'b0);
    checkOutput("idleBusy", busy_o, 1'b0);
    checkOutput("countHeld", blocks_done_o, n);
  endtask

  task automatic fullJob(input int n, input logic [31:0] key, input logic [31:0] src,
                         input logic [31:0] dst, input int srcDly, input int sinkDly,
                         input int earlySinkAt, input bit extra);
    applyStimulus(n, key, src, dst);
    keyPhase(key);
    expandPhase();
    dataPhase(n, src, dst, srcDly, sinkDly);
    blockPhase(n, earlySinkAt);
    finishJob(n, earlySinkAt >= 0, extra);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; n_blocks_i = '0;
    key_addr_i = '0; src_addr_i = '0; dst_addr_i = '0;
    src_ack_i = 1'b0; src_done_i = 1'b0; sink_ack_i = 1'b0; sink_done_i = 1'b0;
    eng_expand_done_i = 1'b0; eng_block_done_i = 1'b0;
    #23;
    checkOutput("resetOutputs", allOutputs(), '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    checkOutput("idleOutputs", allOutputs(), '0);

    $display("[TB] nominal job n=3");
    fullJob(3, 32'h1000, 32'h2000, 32'h3000, 0, 0, -1, 1'b0);

    $display("[TB] zero-block job");
    applyStimulus(0, 32'h1111, 32'h2222, 32'h3333);
    checkOutput("zeroDone", done_o, 1'b1);
    checkOutput("zeroBusy", busy_o, 1'b0);
    checkOutput("zeroCount", blocks_done_o, 0);
    checkOutput("zeroReqs", {src_req_o, sink_req_o, eng_expand_o}, 3'b000);
    tick();
    checkOutput("zeroDoneOnce", done_o, 1'b0);

    $display("[TB] ack skew job n=2");
    fullJob(2, 32'h1400, 32'h2400, 32'h3400, 5, 2, -1, 1'b0);

    $display("[TB] early sink done n=4");
    fullJob(4, 32'h1800, 32'h2800, 32'h3800, 1, 1, 2, 1'b0);

    $display("[TB] extra block pulse n=4");
    fullJob(4, 32'h1c00, 32'h2c00, 32'h3c00, 0, 3, -1, 1'b1);

    $display("[TB] clear during RUN");
    applyStimulus(4, 32'h1a00, 32'h2a00, 32'h3a00);
    keyPhase(32'h1a00);
    expandPhase();
    dataPhase(4, 32'h2a00, 32'h3a00, 0, 0);
    blockPhase(2, -1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checkOutput("clearOutputs", allOutputs(), '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("clearNoDone", done_o, 1'b0);
    end
    expQ.delete();

    $display("[TB] async reset during KEY_LOAD");
    applyStimulus(2, 32'h1e00, 32'h2e00, 32'h3e00);
    keyPhase(32'h1e00);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("asyncResetOutputs", allOutputs(), '0);
    expQ.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    checkOutput("postResetNoDone", done_o, 1'b0);

    $display("[TB] job after abort n=2");
    fullJob(2, 32'h1f00, 32'h2f00, 32'h3f00, 2, 0, -1, 1'b0);

    tick();
    checkOutput("scoreboardEmpty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
